kd_job_sched: RTL and testbench
===============================

Name: kd_job_sched

Overview:
Command scheduler in front of the Kyber/Dilithium NTT core. It queues host jobs, each carrying a KD_mode, a Run_mode and a tag, in a small FIFO. It launches them one at a time: it holds KD_mode stable for a setup window, then drives Run_mode until the core reports done_flag. It returns a tagged response carrying status, done code and run-cycle count, and enforces a timeout and abort, both of which recover the core by pulsing a core reset.

Parameters:
FIFO_DEPTH, 4, command queue entries (power of 2, >=2)
TAG_W, 4, width of job tag
SETUP_CYC, 2, cycles KD_mode is held with Run_mode=0 before launch (>=1)
TIMEOUT, 4096, max RUN cycles before forced timeout (>=2)
RST_CYC, 3, cycles core_rst is held on timeout/abort (>=1)
CYC_W, 16, width of reported cycle count

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
cmd_valid  in  1  host command valid
cmd_ready  out  1  = !fifo_full
cmd_kd_mode  in  1  0 Kyber, 1 Dilithium
cmd_run_mode  in  4  core Run_mode for job; 0 is illegal
cmd_tag  in  TAG_W  job identifier
abort  in  1  cancel current job (level, sampled per cycle)
core_done_flag  in  2  core completion; nonzero = done
core_run_mode  out  4  Run_mode to core
core_kd_mode  out  1  KD_mode to core
core_rst  out  1  reset to core (OR'd with system rst at top)
busy  out  1  high in SETUP, RUN, DRAIN
rsp_valid  out  1  response valid
rsp_ready  in  1  host accepts response
rsp_tag  out  TAG_W  tag of finished job
rsp_status  out  2  00 ok, 01 illegal, 10 timeout, 11 aborted
rsp_done_code  out  2  captured core_done_flag (00 unless status ok)
rsp_cycles  out  CYC_W  RUN-state cycles, saturating at all-ones

Behaviour:
- Reset: FIFO empty, state IDLE, all outputs 0 (core_kd_mode=0, core_run_mode=0, cmd_ready=1 the cycle after reset).
- FIFO push on cmd_valid&&cmd_ready. cmd_ready depends only on full: no push when full, even if a pop occurs in the same cycle. Pointers wrap modulo FIFO_DEPTH.
- IDLE: if FIFO non-empty, pop the head and latch kd/run/tag.
  - run_mode==0: go to RESP with status 01 and rsp_cycles=0. The core is not touched.
  - Otherwise: go to SETUP and load core_kd_mode.
- core_kd_mode holds the last job's value while in IDLE. It never toggles while core_run_mode!=0.
- SETUP: exactly SETUP_CYC cycles, core_run_mode=0. Then RUN.
- RUN: core_run_mode=latched run_mode. The cycle counter starts at 1 in the first RUN cycle.
  - core_done_flag!=0: capture the flag, status 00, go to RESP. core_run_mode=0 from the next cycle.
  - Counter==TIMEOUT with no done: status 10, go to DRAIN.
  - Done and abort in the same cycle: done wins.
  - Done on the timeout cycle: done wins.
- abort in SETUP or RUN (not overridden by done): status 11, go to DRAIN.
- abort in IDLE or RESP is ignored. abort does not flush the FIFO.
- DRAIN: core_rst=1 and core_run_mode=0 for exactly RST_CYC cycles, then RESP.
- RESP: rsp_valid=1. All rsp_* fields stay stable until rsp_valid&&rsp_ready, then return to IDLE.
  - rsp_valid drops in the cycle after the handshake.
  - A queued job is popped in that IDLE cycle, so there is 1 bubble cycle between jobs.
- Latency: a cmd accepted at cycle t into an idle, empty block is popped at t+1. SETUP covers t+2..t+1+SETUP_CYC. First RUN cycle is t+2+SETUP_CYC.
- Only one job is in flight. Responses are returned in command order.
- rst mid-operation: the block returns to the reset state next cycle. The FIFO contents and any in-flight job are discarded with no response.

Test Plan:
- Single Kyber job: cmd kd=0, run=4'd1, tag=3. Core returns done_flag=2'b01 after 10 RUN cycles. Required: core_run_mode=1 for exactly 10 cycles, then rsp tag=3, status=00, done_code=01, cycles=10.
- Back-to-back queue: push 4 cmds with tags 0..3 while the first is running; a 5th push sees cmd_ready=0. Required: 4 responses in tag order 0..3, 1 IDLE bubble between each. core_kd_mode changes only during SETUP.
- Illegal command: run_mode=0, tag=5. Required: rsp status=01, cycles=0; core_run_mode and core_rst never assert.
- Timeout: TIMEOUT=16, core never signals done. Required: 16 RUN cycles, then core_rst high for 3 cycles, then rsp status=10, cycles=16.
- Abort/done collision: abort asserted in the same cycle done_flag=2'b10 arrives. Required: status=00, done_code=10, no core_rst. A separate abort in SETUP gives status=11 and a 3-cycle core_rst.
- Response backpressure and reset: hold rsp_ready=0 for 20 cycles. Required: rsp fields stable and no next job started. Then assert rst with 2 jobs queued. Required: all outputs 0 next cycle, and no responses after reset.

Source files
------------

// File: rtl/kd_job_sched.sv
// Job scheduler for the Kyber/Dilithium NTT core: queues tagged host jobs, sequences
// KD_mode setup, Run_mode launch, done/timeout/abort handling and tagged responses.
module kd_job_sched #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned TAG_W      = 4,
    parameter int unsigned SETUP_CYC  = 2,
    parameter int unsigned TIMEOUT    = 4096,
    parameter int unsigned RST_CYC    = 3,
    parameter int unsigned CYC_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_kd_mode,
    input  logic [3:0]       cmd_run_mode,
    input  logic [TAG_W-1:0] cmd_tag,
    input  logic             abort,
    input  logic [1:0]       core_done_flag,
    output logic [3:0]       core_run_mode,
    output logic             core_kd_mode,
    output logic             core_rst,
    output logic             busy,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [TAG_W-1:0] rsp_tag,
    output logic [1:0]       rsp_status,
    output logic [1:0]       rsp_done_code,
    output logic [CYC_W-1:0] rsp_cycles
);

    localparam int unsigned AW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW     = AW + 1;
    localparam int unsigned TO_W   = $clog2(TIMEOUT + 1);
    // One spare bit keeps the saturation compare meaningful for every parameter set
    localparam int unsigned CNT_W  = ((TO_W > CYC_W) ? TO_W : CYC_W) + 1;
    localparam int unsigned PH_MAX = (SETUP_CYC > RST_CYC) ? SETUP_CYC : RST_CYC;
    localparam int unsigned PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
    localparam logic [CNT_W-1:0] CYC_MAX = CNT_W'({CYC_W{1'b1}});

    localparam logic [1:0] ST_OK  = 2'b00;
    localparam logic [1:0] ST_ILL = 2'b01;
    localparam logic [1:0] ST_TO  = 2'b10;
    localparam logic [1:0] ST_ABT = 2'b11;

    typedef struct packed {
        logic             kd;
        logic [3:0]       run;
        logic [TAG_W-1:0] tag;
    } job_t;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    job_t             r_mem [FIFO_DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_cmd_ready;

    state_t           r_state;
    state_t           w_state_nxt;
    job_t             r_job;
    logic [PH_W-1:0]  r_ph_cnt;
    logic [CNT_W-1:0] r_run_cnt;

    logic [3:0]       r_core_run_mode;
    logic             r_core_kd_mode;
    logic             r_core_rst;
    logic             r_busy;
    logic             r_rsp_valid;
    logic [TAG_W-1:0] r_rsp_tag;
    logic [1:0]       r_rsp_status;
    logic [1:0]       r_rsp_done_code;
    logic [CYC_W-1:0] r_rsp_cycles;

    logic             w_push;
    logic             w_pop;
    logic [CW-1:0]    w_count_nxt;
    job_t             w_head;
    logic             w_done;
    logic             w_setup_last;
    logic             w_drain_last;
    logic             w_timeout;
    logic [CYC_W-1:0] w_cyc_sat;

    logic             w_res_load;
    logic [1:0]       w_res_status;
    logic [1:0]       w_res_code;
    logic [CYC_W-1:0] w_res_cycles;
    logic [TAG_W-1:0] w_res_tag;
    logic [3:0]       w_run_nxt;
    logic             w_rst_nxt;
    logic             w_busy_nxt;
    logic             w_rsp_valid_nxt;

    assign w_push       = cmd_valid && r_cmd_ready;
    assign w_pop        = (r_state == S_IDLE) && (r_count != '0);
    assign w_count_nxt  = r_count + CW'(w_push) - CW'(w_pop);
    assign w_head       = r_mem[r_rd_ptr];
    assign w_done       = (core_done_flag != 2'b00);
    assign w_setup_last = (r_ph_cnt == PH_W'(SETUP_CYC - 1));
    assign w_drain_last = (r_ph_cnt == PH_W'(RST_CYC - 1));
    assign w_timeout    = (r_run_cnt == CNT_W'(TIMEOUT));
    assign w_cyc_sat    = (r_run_cnt > CYC_MAX) ? {CYC_W{1'b1}} : CYC_W'(r_run_cnt);

    // Command queue; ready is a registered function of fill level only
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_cmd_ready <= 1'b1;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count     <= w_count_nxt;
            r_cmd_ready <= (w_count_nxt != CW'(FIFO_DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= '{kd: cmd_kd_mode, run: cmd_run_mode, tag: cmd_tag};
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_pop) w_state_nxt = (w_head.run == 4'd0) ? S_RESP : S_SETUP;
            S_SETUP: begin
                if (abort)             w_state_nxt = S_DRAIN;
                else if (w_setup_last) w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (w_done)                  w_state_nxt = S_RESP;
                else if (abort || w_timeout) w_state_nxt = S_DRAIN;
            end
            S_DRAIN: if (w_drain_last) w_state_nxt = S_RESP;
            S_RESP:  if (rsp_ready)    w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Job outcome (priority done > abort > timeout) and next values of the registered outputs
    always_comb begin
        w_res_load   = 1'b0;
        w_res_status = ST_OK;
        w_res_code   = 2'b00;
        w_res_cycles = w_cyc_sat;
        w_res_tag    = r_job.tag;
        case (r_state)
            S_IDLE: begin
                if (w_pop && (w_head.run == 4'd0)) begin
                    w_res_load   = 1'b1;
                    w_res_status = ST_ILL;
                    w_res_cycles = '0;
                    w_res_tag    = w_head.tag;
                end
            end
            S_SETUP: begin
                if (abort) begin
                    w_res_load   = 1'b1;
                    w_res_status = ST_ABT;
                end
            end
            S_RUN: begin
                if (w_done) begin
                    w_res_load = 1'b1;
                    w_res_code = core_done_flag;
                end else if (abort) begin
                    w_res_load   = 1'b1;
                    w_res_status = ST_ABT;
                end else if (w_timeout) begin
                    w_res_load   = 1'b1;
                    w_res_status = ST_TO;
                end
            end
            default: ;
        endcase
        w_run_nxt       = (w_state_nxt == S_RUN) ? r_job.run : 4'd0;
        w_rst_nxt       = (w_state_nxt == S_DRAIN);
        w_busy_nxt      = (w_state_nxt == S_SETUP) || (w_state_nxt == S_RUN) ||
                          (w_state_nxt == S_DRAIN);
        w_rsp_valid_nxt = (w_state_nxt == S_RESP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_job           <= '0;
            r_ph_cnt        <= '0;
            r_run_cnt       <= '0;
            r_core_run_mode <= 4'd0;
            r_core_kd_mode  <= 1'b0;
            r_core_rst      <= 1'b0;
            r_busy          <= 1'b0;
            r_rsp_valid     <= 1'b0;
            r_rsp_tag       <= '0;
            r_rsp_status    <= 2'b00;
            r_rsp_done_code <= 2'b00;
            r_rsp_cycles    <= '0;
        end else begin
            if (w_pop) begin
                r_job <= w_head;
                // Illegal jobs never reach the core, so KD_mode keeps the last launched value
                if (w_head.run != 4'd0) r_core_kd_mode <= w_head.kd;
            end
            if (w_state_nxt != r_state) begin
                r_ph_cnt <= '0;
            end else if ((r_state == S_SETUP) || (r_state == S_DRAIN)) begin
                r_ph_cnt <= r_ph_cnt + PH_W'(1);
            end
            if (w_pop)                       r_run_cnt <= '0;
            else if (w_state_nxt == S_RUN)   r_run_cnt <= r_run_cnt + CNT_W'(1);
            r_core_run_mode <= w_run_nxt;
            r_core_rst      <= w_rst_nxt;
            r_busy          <= w_busy_nxt;
            r_rsp_valid     <= w_rsp_valid_nxt;
            if (w_res_load) begin
                r_rsp_tag       <= w_res_tag;
                r_rsp_status    <= w_res_status;
                r_rsp_done_code <= w_res_code;
                r_rsp_cycles    <= w_res_cycles;
            end
        end
    end

    assign cmd_ready     = r_cmd_ready;
    assign core_run_mode = r_core_run_mode;
    assign core_kd_mode  = r_core_kd_mode;
    assign core_rst      = r_core_rst;
    assign busy          = r_busy;
    assign rsp_valid     = r_rsp_valid;
    assign rsp_tag       = r_rsp_tag;
    assign rsp_status    = r_rsp_status;
    assign rsp_done_code = r_rsp_done_code;
    assign rsp_cycles    = r_rsp_cycles;

endmodule

// File: tb/tb_kd_job_sched.sv
// Directed bench for kd_job_sched: single job, queueing, illegal, timeout, abort,
// backpressure and mid-operation reset, with hand-computed expectations.
module tb_kd_job_sched;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_kd_mode;
    logic [3:0]  cmd_run_mode;
    logic [3:0]  cmd_tag;
    logic        abort;
    logic [1:0]  core_done_flag;
    logic [3:0]  core_run_mode;
    logic        core_kd_mode;
    logic        core_rst;
    logic        busy;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [3:0]  rsp_tag;
    logic [1:0]  rsp_status;
    logic [1:0]  rsp_done_code;
    logic [15:0] rsp_cycles;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    kd_job_sched #(
        .FIFO_DEPTH(4),
        .TAG_W     (4),
        .SETUP_CYC (2),
        .TIMEOUT   (16),
        .RST_CYC   (3),
        .CYC_W     (16)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_kd_mode   (cmd_kd_mode),
        .cmd_run_mode  (cmd_run_mode),
        .cmd_tag       (cmd_tag),
        .abort         (abort),
        .core_done_flag(core_done_flag),
        .core_run_mode (core_run_mode),
        .core_kd_mode  (core_kd_mode),
        .core_rst      (core_rst),
        .busy          (busy),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_tag       (rsp_tag),
        .rsp_status    (rsp_status),
        .rsp_done_code (rsp_done_code),
        .rsp_cycles    (rsp_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_cmd(input logic kd, input logic [3:0] run, input logic [3:0] tag);
        cmd_valid    = 1'b1;
        cmd_kd_mode  = kd;
        cmd_run_mode = run;
        cmd_tag      = tag;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_run"},    32'(core_run_mode), 32'd0);
        chk({tag, "_kd"},     32'(core_kd_mode),  32'd0);
        chk({tag, "_crst"},   32'(core_rst),      32'd0);
        chk({tag, "_busy"},   32'(busy),          32'd0);
        chk({tag, "_rvalid"}, 32'(rsp_valid),     32'd0);
        chk({tag, "_rtag"},   32'(rsp_tag),       32'd0);
        chk({tag, "_rstat"},  32'(rsp_status),    32'd0);
        chk({tag, "_rcode"},  32'(rsp_done_code), 32'd0);
        chk({tag, "_rcyc"},   32'(rsp_cycles),    32'd0);
        chk({tag, "_ready"},  32'(cmd_ready),     32'd1);
    endtask

    // Waits (bounded) for the first RUN cycle
    task automatic wait_run(input string tag);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (core_run_mode != 4'd0) got = 1'b1;
            else @(negedge clk);
        end
        chk({tag, "_run_start"}, 32'(got), 32'd1);
    endtask

    // Runs a job from its SETUP to a done after nrun RUN cycles, then handshakes
    task automatic run_job(input logic [3:0] tag, input logic kd, input logic [3:0] run,
                           input int nrun);
        string p;
        p = $sformatf("job%0d", tag);
        wait_run(p);
        chk({p, "_mode"}, 32'(core_run_mode), 32'(run));
        chk({p, "_kd"},   32'(core_kd_mode),  32'(kd));
        repeat (nrun - 1) @(negedge clk);
        chk({p, "_hold"}, 32'(core_run_mode), 32'(run));
        core_done_flag = 2'b01;
        @(negedge clk);
        core_done_flag = 2'b00;
        chk({p, "_rvalid"}, 32'(rsp_valid),     32'd1);
        chk({p, "_rtag"},   32'(rsp_tag),       32'(tag));
        chk({p, "_rstat"},  32'(rsp_status),    32'd0);
        chk({p, "_rcode"},  32'(rsp_done_code), 32'd1);
        chk({p, "_rcyc"},   32'(rsp_cycles),    32'(nrun));
        chk({p, "_off"},    32'(core_run_mode), 32'd0);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk({p, "_rdrop"},  32'(rsp_valid),    32'd0);
        chk({p, "_bubble"}, 32'(busy),         32'd0);
        chk({p, "_kdhold"}, 32'(core_kd_mode), 32'(kd));
    endtask

    initial begin
        int   n;
        logic stop;

        rst            = 1'b1;
        cmd_valid      = 1'b0;
        cmd_kd_mode    = 1'b0;
        cmd_run_mode   = 4'd0;
        cmd_tag        = 4'd0;
        abort          = 1'b0;
        core_done_flag = 2'b00;
        rsp_ready      = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset_state("reset");
        rst = 1'b0;
        @(negedge clk);

        // Single Kyber job with exact launch latency and 10 RUN cycles
        chk("t1_ready", 32'(cmd_ready), 32'd1);
        set_cmd(1'b0, 4'd1, 4'd3);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("t1_pop_busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("t1_setup_busy", 32'(busy), 32'd1);
        chk("t1_setup_run", 32'(core_run_mode), 32'd0);
        @(negedge clk);
        chk("t1_setup2_run", 32'(core_run_mode), 32'd0);
        @(negedge clk);
        chk("t1_first_run", 32'(core_run_mode), 32'd1);
        n = 1;
        repeat (8) begin
            @(negedge clk);
            if (core_run_mode == 4'd1) n++;
        end
        @(negedge clk);
        if (core_run_mode == 4'd1) n++;
        chk("t1_run_count", 32'(n), 32'd10);
        core_done_flag = 2'b01;
        @(negedge clk);
        core_done_flag = 2'b00;
        chk("t1_run_off", 32'(core_run_mode), 32'd0);
        chk("t1_rvalid", 32'(rsp_valid), 32'd1);
        chk("t1_rtag", 32'(rsp_tag), 32'd3);
        chk("t1_rstat", 32'(rsp_status), 32'd0);
        chk("t1_rcode", 32'(rsp_done_code), 32'd1);
        chk("t1_rcyc", 32'(rsp_cycles), 32'd10);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("t1_rdrop", 32'(rsp_valid), 32'd0);

        // Illegal command never touches the core
        set_cmd(1'b1, 4'd0, 4'd5);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("ill_busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("ill_rvalid", 32'(rsp_valid), 32'd1);
        chk("ill_rstat", 32'(rsp_status), 32'd1);
        chk("ill_rcyc", 32'(rsp_cycles), 32'd0);
        chk("ill_rtag", 32'(rsp_tag), 32'd5);
        chk("ill_rcode", 32'(rsp_done_code), 32'd0);
        chk("ill_run", 32'(core_run_mode), 32'd0);
        chk("ill_crst", 32'(core_rst), 32'd0);
        chk("ill_kd", 32'(core_kd_mode), 32'd0);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("ill_rdrop", 32'(rsp_valid), 32'd0);

        // Back-to-back queue: tag 8 runs while tags 0..3 fill the FIFO, tag 9 is refused
        set_cmd(1'b0, 4'd3, 4'd8);
        @(negedge clk);
        chk("b2b_ready0", 32'(cmd_ready), 32'd1);
        set_cmd(1'b1, 4'd2, 4'd0);
        @(negedge clk);
        chk("b2b_ready1", 32'(cmd_ready), 32'd1);
        set_cmd(1'b0, 4'd3, 4'd1);
        @(negedge clk);
        chk("b2b_ready2", 32'(cmd_ready), 32'd1);
        set_cmd(1'b1, 4'd4, 4'd2);
        @(negedge clk);
        chk("b2b_ready3", 32'(cmd_ready), 32'd1);
        set_cmd(1'b0, 4'd5, 4'd3);
        @(negedge clk);
        chk("b2b_full", 32'(cmd_ready), 32'd0);
        set_cmd(1'b1, 4'd7, 4'd9);
        @(negedge clk);
        chk("b2b_full2", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        chk("b2b_full3", 32'(cmd_ready), 32'd0);
        chk("b2b_t8_run", 32'(core_run_mode), 32'd3);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("b2b_t8_run5", 32'(core_run_mode), 32'd3);
        core_done_flag = 2'b01;
        @(negedge clk);
        core_done_flag = 2'b00;
        chk("b2b_t8_rvalid", 32'(rsp_valid), 32'd1);
        chk("b2b_t8_rtag", 32'(rsp_tag), 32'd8);
        chk("b2b_t8_rcyc", 32'(rsp_cycles), 32'd5);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("b2b_t8_rdrop", 32'(rsp_valid), 32'd0);
        chk("b2b_t8_bubble", 32'(busy), 32'd0);
        chk("b2b_t8_kdhold", 32'(core_kd_mode), 32'd0);
        chk("b2b_still_full", 32'(cmd_ready), 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("b2b_setup_busy%0d", i), 32'(busy), 32'd1);
            chk($sformatf("b2b_setup_kd%0d", i), 32'(core_kd_mode), 32'((i % 2) == 0));
            chk($sformatf("b2b_setup_run%0d", i), 32'(core_run_mode), 32'd0);
            run_job(4'(i), 1'((i % 2) == 0), 4'(i + 2), 3);
        end
        repeat (3) begin
            @(negedge clk);
            chk("b2b_no_t9_busy", 32'(busy), 32'd0);
            chk("b2b_no_t9_rvalid", 32'(rsp_valid), 32'd0);
        end

        // Timeout: core never answers
        set_cmd(1'b1, 4'd5, 4'd7);
        @(negedge clk);
        cmd_valid = 1'b0;
        wait_run("to");
        n    = 1;
        stop = 1'b0;
        for (int i = 0; i < 40 && !stop; i++) begin
            @(negedge clk);
            if (core_run_mode != 4'd0) n++;
            else stop = 1'b1;
        end
        chk("to_run_cycles", 32'(n), 32'd16);
        chk("to_crst1", 32'(core_rst), 32'd1);
        chk("to_busy", 32'(busy), 32'd1);
        chk("to_rvalid_early", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        chk("to_crst2", 32'(core_rst), 32'd1);
        @(negedge clk);
        chk("to_crst3", 32'(core_rst), 32'd1);
        @(negedge clk);
        chk("to_crst_off", 32'(core_rst), 32'd0);
        chk("to_rvalid", 32'(rsp_valid), 32'd1);
        chk("to_rstat", 32'(rsp_status), 32'd2);
        chk("to_rcyc", 32'(rsp_cycles), 32'd16);
        chk("to_rtag", 32'(rsp_tag), 32'd7);
        chk("to_rcode", 32'(rsp_done_code), 32'd0);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;

        // Abort collides with done: done wins
        set_cmd(1'b0, 4'd6, 4'd10);
        @(negedge clk);
        cmd_valid = 1'b0;
        wait_run("col");
        repeat (2) @(negedge clk);
        abort          = 1'b1;
        core_done_flag = 2'b10;
        @(negedge clk);
        abort          = 1'b0;
        core_done_flag = 2'b00;
        chk("col_rvalid", 32'(rsp_valid), 32'd1);
        chk("col_rstat", 32'(rsp_status), 32'd0);
        chk("col_rcode", 32'(rsp_done_code), 32'd2);
        chk("col_rcyc", 32'(rsp_cycles), 32'd3);
        chk("col_rtag", 32'(rsp_tag), 32'd10);
        chk("col_crst", 32'(core_rst), 32'd0);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;

        // Abort during SETUP
        set_cmd(1'b1, 4'd9, 4'd11);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("abs_busy", 32'(busy), 32'd1);
        chk("abs_run", 32'(core_run_mode), 32'd0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abs_crst1", 32'(core_rst), 32'd1);
        chk("abs_run_off", 32'(core_run_mode), 32'd0);
        @(negedge clk);
        chk("abs_crst2", 32'(core_rst), 32'd1);
        @(negedge clk);
        chk("abs_crst3", 32'(core_rst), 32'd1);
        @(negedge clk);
        chk("abs_crst_off", 32'(core_rst), 32'd0);
        chk("abs_rvalid", 32'(rsp_valid), 32'd1);
        chk("abs_rstat", 32'(rsp_status), 32'd3);
        chk("abs_rcyc", 32'(rsp_cycles), 32'd0);
        chk("abs_rtag", 32'(rsp_tag), 32'd11);
        chk("abs_rcode", 32'(rsp_done_code), 32'd0);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;

        // Backpressure with two jobs queued, then reset
        set_cmd(1'b1, 4'd1, 4'd12);
        @(negedge clk);
        set_cmd(1'b0, 4'd2, 4'd13);
        @(negedge clk);
        set_cmd(1'b1, 4'd3, 4'd14);
        @(negedge clk);
        cmd_valid = 1'b0;
        wait_run("bp");
        core_done_flag = 2'b01;
        @(negedge clk);
        core_done_flag = 2'b00;
        repeat (20) begin
            chk("bp_rvalid", 32'(rsp_valid), 32'd1);
            chk("bp_rtag", 32'(rsp_tag), 32'd12);
            chk("bp_rstat", 32'(rsp_status), 32'd0);
            chk("bp_rcode", 32'(rsp_done_code), 32'd1);
            chk("bp_rcyc", 32'(rsp_cycles), 32'd1);
            chk("bp_busy", 32'(busy), 32'd0);
            chk("bp_run", 32'(core_run_mode), 32'd0);
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        chk_reset_state("midrst");
        rst = 1'b0;
        rsp_ready = 1'b1;
        repeat (30) begin
            @(negedge clk);
            chk("post_rst_rvalid", 32'(rsp_valid), 32'd0);
            chk("post_rst_busy", 32'(busy), 32'd0);
        end
        rsp_ready = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
